// File: rtl/lsu_byte_sequencer.sv
// rtl/lsu_byte_sequencer.sv - byte-serial load/store initiator with little-endian assembly and extension
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned requests with resp_err instead of executing them.

module lsu_byte_sequencer #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, ST, RD_REQ, RD_CAP, RESP} state_t;

    state_t              state;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [63:0]         wdata_q;
    logic [63:0]         asm_q;
    logic [2:0]          k;

    logic [2:0]          last_k;
    logic [2:0]          k_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [63:0]         asm_new;

    assign last_k   = 3'((4'd1 << size_q) - 4'd1);
    assign k_nxt    = k + 3'd1;
    assign addr_nxt = addr_q + ADDR_W'(k_nxt);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = |(req_addr[2:0] & 3'((4'd1 << req_size) - 4'd1));
`endif

    // Assembly register with the byte arriving this cycle already merged in
    always_comb begin
        asm_new = asm_q;
        asm_new[{k, 3'b000} +: 8] = mem_rdata;
    end

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz, input logic uns);
        logic [63:0] r;
        case (sz)
            2'd0:    r = {{56{~uns & d[7]}},  d[7:0]};
            2'd1:    r = {{48{~uns & d[15]}}, d[15:0]};
            2'd2:    r = {{32{~uns & d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 64'd0;
            asm_q      <= 64'd0;
            k          <= 3'd0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'd0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        asm_q      <= 64'd0;
                        k          <= 3'd0;
                        resp_rdata <= 64'd0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else
`endif
                        begin
                            // First strobe goes out in the cycle right after accept
                            mem_addr <= req_addr;
                            if (req_write) begin
                                state     <= ST;
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata[7:0];
                            end else begin
                                state  <= RD_REQ;
                                mem_re <= 1'b1;
                            end
                        end
                    end
                end
                ST: begin
                    if (k == last_k) begin
                        mem_we     <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= 64'd0;
                    end else begin
                        k         <= k_nxt;
                        mem_addr  <= addr_nxt;
                        mem_wdata <= wdata_q[{k_nxt, 3'b000} +: 8];
                    end
                end
                RD_REQ: begin
                    mem_re <= 1'b0;
                    state  <= RD_CAP;
                end
                RD_CAP: begin
                    asm_q <= asm_new;
                    if (k == last_k) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= extend(asm_new, size_q, uns_q);
                    end else begin
                        k        <= k_nxt;
                        mem_re   <= 1'b1;
                        mem_addr <= addr_nxt;
                        state    <= RD_REQ;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    mem_re    <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb/tb_lsu_byte_sequencer.sv - table-driven bench for lsu_byte_sequencer with a byte memory model

module tb_lsu_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;
    logic        busy;

    lsu_byte_sequencer #(.ADDR_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [logic [63:0]];

    function automatic logic [7:0] rdmem(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= rdmem(mem_addr);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        int          exp_cyc;
        logic        exp_err;
        int          exp_we;
        int          exp_re;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int nwe = 0;
        int nre = 0;
        int nviol = 0;
        int cyc = -1;
        logic [63:0] rd = 64'd0;
        logic er = 1'b0;
        @(negedge clk);
        check({v.name, "_ready_before"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = v.wr; req_size = v.sz;
        req_unsigned = v.uns; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 64'h0; req_wdata = 64'h0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_we && mem_re) nviol++;
            if (req_ready || !busy) nviol++;
            if (mem_we) begin
                if (nwe >= 8 || mem_addr !== v.addr + 64'(nwe) || mem_wdata !== v.wdata[8*nwe +: 8]) nviol++;
                nwe++;
            end
            if (mem_re) begin
                if (nre >= 8 || mem_addr !== v.addr + 64'(nre)) nviol++;
                nre++;
            end
            if (resp_valid) begin
                cyc = c; rd = resp_rdata; er = resp_err;
                if (mem_we || mem_re) nviol++;
                break;
            end
        end
        check({v.name, "_resp_cycle"}, 64'(cyc), 64'(v.exp_cyc));
        check({v.name, "_rdata"}, rd, v.exp_rd);
        check({v.name, "_err"}, 64'(er), 64'(v.exp_err));
        check({v.name, "_we_count"}, 64'(nwe), 64'(v.exp_we));
        check({v.name, "_re_count"}, 64'(nre), 64'(v.exp_re));
        check({v.name, "_strobe_violations"}, 64'(nviol), 64'd0);
        @(negedge clk);
        check({v.name, "_idle_after"}, {62'd0, resp_valid, req_ready}, 64'd1);
    endtask

    vec_t vecs[9];
    int   saw_resp;

    initial begin
        mem[64'h20] = 8'h80;
        mem[64'h30] = 8'h34; mem[64'h31] = 8'hF2;
        mem[64'h41] = 8'h01; mem[64'h42] = 8'h02; mem[64'h43] = 8'h03; mem[64'h44] = 8'h84;
        for (int i = 0; i < 8; i++) mem[64'h50 + 64'(i)] = 8'(8'hA0 + i);

        vecs[0] = '{"st_double",  1'b1, 2'd3, 1'b0, 64'h10, 64'h8877665544332211, 64'h0, 9, 1'b0, 8, 0};
        vecs[1] = '{"ld_sbyte",   1'b0, 2'd0, 1'b0, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFF80, 3, 1'b0, 0, 1};
        vecs[2] = '{"ld_uhalf",   1'b0, 2'd1, 1'b1, 64'h30, 64'h0, 64'h000000000000F234, 5, 1'b0, 0, 2};
        vecs[3] = '{"ld_shalf",   1'b0, 2'd1, 1'b0, 64'h30, 64'h0, 64'hFFFFFFFFFFFFF234, 5, 1'b0, 0, 2};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[4] = '{"ld_mis_word", 1'b0, 2'd2, 1'b0, 64'h41, 64'h0, 64'h0, 1, 1'b1, 0, 0};
        vecs[5] = '{"st_wrap",     1'b1, 2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hBBAA, 64'h0, 1, 1'b1, 0, 0};
`else
        vecs[4] = '{"ld_mis_word", 1'b0, 2'd2, 1'b0, 64'h41, 64'h0, 64'hFFFFFFFF84030201, 9, 1'b0, 0, 4};
        vecs[5] = '{"st_wrap",     1'b1, 2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hBBAA, 64'h0, 3, 1'b0, 2, 0};
`endif
        vecs[6] = '{"ld_double",  1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h8877665544332211, 17, 1'b0, 0, 8};
        vecs[7] = '{"ld_uword",   1'b0, 2'd2, 1'b1, 64'h14, 64'h0, 64'h0000000088776655, 9, 1'b0, 0, 4};
        vecs[8] = '{"ld_ubyte",   1'b0, 2'd0, 1'b1, 64'h20, 64'h0, 64'h0000000000000080, 3, 1'b0, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_outputs", {60'd0, resp_valid, resp_err, mem_re, mem_we}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready_released", 64'(req_ready), 64'd1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

`ifdef LSU_MISALIGN_TRAP_EN
        check("wrap_mem_ff", 64'(rdmem(64'hFFFFFFFFFFFFFFFF)), 64'h00);
        check("wrap_mem_00", 64'(rdmem(64'h0)), 64'h00);
`else
        check("wrap_mem_ff", 64'(rdmem(64'hFFFFFFFFFFFFFFFF)), 64'hAA);
        check("wrap_mem_00", 64'(rdmem(64'h0)), 64'hBB);
`endif
        check("st_mem_17", 64'(rdmem(64'h17)), 64'h88);

        // Reset during cycle 3 of a double load: no response, back to IDLE
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h50;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        saw_resp = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) saw_resp++;
        end
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_strobes", {62'd0, mem_re, mem_we}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) saw_resp++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        if (resp_valid) saw_resp++;
        check("midrst_no_resp", 64'(saw_resp), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd1);
        run_vec('{"post_rst_ld_sbyte", 1'b0, 2'd0, 1'b0, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFF80, 3, 1'b0, 0, 1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
